// File: rtl/adder_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_acc_pkg
// Description : Shared definitions for the adder sum accumulator.
//               - FSM state encoding (ACCUM / DONE)
//               - Default widths for the sample input, accumulator and window
//               - cnt_w(): width of a counter that must reach WIN_LEN
//               Configuration macro used by the design: ACC_SATURATE_EN
// Revision    : 1.0 - initial release
// ============================================================================
package adder_acc_pkg;

  // Accumulator FSM. ACCUM gathers samples; DONE presents the window total.
  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_e;

  // Default configuration
  localparam int c_DEF_IN_W    = 4;
  localparam int c_DEF_ACC_W   = 12;
  localparam int c_DEF_WIN_LEN = 16;

  // The sample counter has to hold the value WIN_LEN itself (it is presented
  // in DONE), hence the +1.
  function automatic int cnt_w(input int win_len);
    return $clog2(win_len + 1);
  endfunction

endpackage : adder_acc_pkg
`default_nettype wire

// File: rtl/acc_add_sat.sv
`default_nettype none
// ============================================================================
// Module      : acc_add_sat
// Description : Combinational accumulator adder.
//               res_o = acc_i + zero-extended sample_i, computed ACC_W+1 wide
//               so the carry out of the ACC_W-bit result is visible.
//               Configuration macro: ACC_SATURATE_EN
//                 defined   : result clamps to 2^ACC_W-1 on carry
//                 undefined : result wraps modulo 2^ACC_W
//               carry_o reports the raw carry in both builds.
// Ports       : acc_i     in  ACC_W   current accumulator value
//               sample_i  in  IN_W+1  sample {carry, sum}
//               res_o     out ACC_W   next accumulator value
//               carry_o   out 1       the add exceeded 2^ACC_W-1
// Revision    : 1.0 - initial release
// ============================================================================
module acc_add_sat #(
  parameter int IN_W  = 4,
  parameter int ACC_W = 12
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [IN_W:0]    sample_i,
  output logic [ACC_W-1:0] res_o,
  output logic             carry_o
);

  logic [ACC_W:0] w_sum;

  // Both operands extended to ACC_W+1 bits; ACC_W > IN_W+1 keeps the zero
  // pad width positive.
  assign w_sum   = {1'b0, acc_i} + {{(ACC_W - IN_W){1'b0}}, sample_i};
  assign carry_o = w_sum[ACC_W];

`ifdef ACC_SATURATE_EN
  // Once clamped at all-ones, any non-zero sample carries again, so the
  // value stays pinned for the rest of the window.
  assign res_o = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign res_o = w_sum[ACC_W-1:0];
`endif

endmodule : acc_add_sat
`default_nettype wire

// File: rtl/adder_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : adder_sum_accumulator
// Description : Accumulates WIN_LEN adder results {c_out, sum} into an ACC_W
//               register and hands the window total off over a valid/ready
//               handshake, then restarts with the next window.
//               Configuration macro: ACC_SATURATE_EN (clamp instead of wrap
//               inside acc_add_sat).
// Ports       : clk         in   1        clock, rising edge
//               rst_n       in   1        asynchronous active-low reset
//               clr         in   1        synchronous window clear (top prio)
//               in_valid    in   1        sample valid
//               in_ready    out  1        sample can be accepted
//               sum_in      in   IN_W     adder sum
//               c_out_in    in   1        adder carry-out
//               acc_valid   out  1        acc_out is a completed window total
//               acc_ready   in   1        consumer takes acc_out
//               acc_out     out  ACC_W    running / final total
//               sample_cnt  out  cnt_w    samples accepted in this window
//               ovf         out  1        sticky accumulator overflow
// Revision    : 1.0 - initial release
// ============================================================================
module adder_sum_accumulator
  import adder_acc_pkg::*;
#(
  parameter int IN_W    = c_DEF_IN_W,
  parameter int ACC_W   = c_DEF_ACC_W,
  parameter int WIN_LEN = c_DEF_WIN_LEN
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            sum_in,
  input  logic                       c_out_in,
  output logic                       acc_valid,
  input  logic                       acc_ready,
  output logic [ACC_W-1:0]           acc_out,
  output logic [cnt_w(WIN_LEN)-1:0]  sample_cnt,
  output logic                       ovf
);

  localparam int CNT_W = cnt_w(WIN_LEN);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q,   acc_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             ovf_q,   ovf_d;

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  logic [IN_W:0]    w_sample;
  logic [ACC_W-1:0] w_add_res;
  logic             w_add_carry;
  logic             w_accept;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_win_last;

  assign w_sample = {c_out_in, sum_in};

  acc_add_sat #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_add (
    .acc_i    (acc_q),
    .sample_i (w_sample),
    .res_o    (w_add_res),
    .carry_o  (w_add_carry)
  );

  // in_ready is a pure decode of the state register, so in_valid never
  // reaches it combinationally.
  assign in_ready  = (state_q == ST_ACCUM);
  assign acc_valid = (state_q == ST_DONE);

  assign w_accept   = in_valid & in_ready;
  assign w_cnt_inc  = cnt_q + CNT_W'(1);
  assign w_win_last = (w_cnt_inc == CNT_W'(WIN_LEN));

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    if (clr) begin
      // Clear wins over any concurrent sample or output handshake.
      state_d = ST_ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (w_accept) begin
            acc_d = w_add_res;
            cnt_d = w_cnt_inc;
            ovf_d = ovf_q | w_add_carry;
            if (w_win_last) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // Total, count and ovf are frozen until the consumer takes them.
          // The handshake cycle accepts no sample: one bubble per window.
          if (acc_ready) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: begin
          state_d = ST_ACCUM;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign acc_out    = acc_q;
  assign sample_cnt = cnt_q;
  assign ovf        = ovf_q;

endmodule : adder_sum_accumulator
`default_nettype wire

// File: tb/tb_adder_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_sum_accumulator
// Description : Self-checking bench for adder_sum_accumulator. A default
//               instance (ACC_W=12) is driven through reset, window,
//               backpressure, clear and exhaustive adder streams; expected
//               window totals are queued when samples are driven and popped
//               when the output handshake fires. A second instance with
//               ACC_W=8 exercises overflow (wrap, or clamp with
//               ACC_SATURATE_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_sum_accumulator;

  localparam int IN_W    = 4;
  localparam int ACC_W   = 12;
  localparam int WIN_LEN = 16;
  localparam int CNT_W   = $clog2(WIN_LEN + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  sum_in;
  logic             c_out_in;
  logic             acc_valid;
  logic             acc_ready;
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] sample_cnt;
  logic             ovf;

  // Narrow-accumulator instance for the overflow test
  logic             in_valid8;
  logic             in_ready8;
  logic             acc_valid8;
  logic [7:0]       acc_out8;
  logic [CNT_W-1:0] sample_cnt8;
  logic             ovf8;

  int total = 0;
  int bad   = 0;

  // Scoreboard: {ovf, total} per completed window
  logic [ACC_W:0] exp_q[$];
  int             m_acc;
  int             m_cnt;

  always #5 clk = ~clk;

  adder_sum_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .WIN_LEN(WIN_LEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sum_in     (sum_in),
    .c_out_in   (c_out_in),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .acc_out    (acc_out),
    .sample_cnt (sample_cnt),
    .ovf        (ovf)
  );

  adder_sum_accumulator #(.IN_W(IN_W), .ACC_W(8), .WIN_LEN(WIN_LEN)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (in_valid8),
    .in_ready   (in_ready8),
    .sum_in     (sum_in),
    .c_out_in   (c_out_in),
    .acc_valid  (acc_valid8),
    .acc_ready  (1'b0),
    .acc_out    (acc_out8),
    .sample_cnt (sample_cnt8),
    .ovf        (ovf8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_cnt = 0;
  endtask

  // Drive one sample and wait (bounded) until the DUT accepts it; the
  // reference model is updated at the accepting edge.
  task automatic send(input logic [3:0] s, input logic c);
    int guard;
    sum_in   = s;
    c_out_in = c;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check("accept_timeout", 32'd0, 32'd1);
    tick();
    m_acc += {c, s};
    m_cnt++;
    if (m_cnt == WIN_LEN) begin
      exp_q.push_back({(m_acc > 4095) ? 1'b1 : 1'b0, ACC_W'(m_acc % 4096)});
      model_reset();
    end
  endtask

  // Output monitor: one pop per completed output handshake
  always @(negedge clk) begin
    if (rst_n && !clr && acc_valid && acc_ready) begin
      check("sb_nonempty", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() != 0) begin
        logic [ACC_W:0] e;
        e = exp_q.pop_front();
        check("win_total", 32'(acc_out), 32'(e[ACC_W-1:0]));
        check("win_ovf", 32'(ovf), 32'(e[ACC_W]));
        check("win_cnt", 32'(sample_cnt), WIN_LEN);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_valid8 = 1'b0;
    sum_in    = '0;
    c_out_in  = 1'b0;
    acc_ready = 1'b1;
    model_reset();
    #1;
    check("rst_acc", 32'(acc_out), 0);
    check("rst_cnt", 32'(sample_cnt), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // ---- 1: asynchronous reset mid-window ----
    for (int i = 0; i < 3; i++) send(4'h7, 1'b1);
    in_valid = 1'b0;
    check("pre_rst_cnt", 32'(sample_cnt), 3);
    rst_n = 1'b0;
    #1;
    check("async_acc", 32'(acc_out), 0);
    check("async_cnt", 32'(sample_cnt), 0);
    check("async_ovf", 32'(ovf), 0);
    check("async_valid", 32'(acc_valid), 0);
    check("async_ready", 32'(in_ready), 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    tick();

    // ---- 2: full window of 31s, consumer ready ----
    for (int i = 0; i < WIN_LEN - 1; i++) send(4'hF, 1'b1);
    check("w2_cnt15", 32'(sample_cnt), 15);
    check("w2_valid_early", 32'(acc_valid), 0);
    send(4'hF, 1'b1);
    in_valid = 1'b0;
    check("w2_valid", 32'(acc_valid), 1);
    check("w2_acc", 32'(acc_out), 496);
    check("w2_ovf", 32'(ovf), 0);
    tick();

    // ---- 3: backpressure ----
    acc_ready = 1'b0;
    for (int i = 0; i < WIN_LEN; i++) send(4'hF, 1'b1);
    sum_in   = 4'h1;
    c_out_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_acc", 32'(acc_out), 496);
    end
    check("bp_cnt", 32'(sample_cnt), WIN_LEN);
    acc_ready = 1'b1;
    send(4'h1, 1'b0);
    in_valid = 1'b0;
    check("bp_new_acc", 32'(acc_out), 1);
    check("bp_new_cnt", 32'(sample_cnt), 1);

    // ---- 4: overflow on the 8-bit instance ----
    sum_in    = 4'hF;
    c_out_in  = 1'b1;
    in_valid8 = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("ov_acc8", 32'(acc_out8), 248);
    check("ov_ovf8_early", 32'(ovf8), 0);
    for (int i = 0; i < 8; i++) tick();
    in_valid8 = 1'b0;
`ifdef ACC_SATURATE_EN
    check("ov_acc16", 32'(acc_out8), 255);
`else
    check("ov_acc16", 32'(acc_out8), 240);
`endif
    check("ov_ovf", 32'(ovf8), 1);
    check("ov_done", 32'(acc_valid8), 1);
    tick();
    check("ov_hold", 32'(sample_cnt8), WIN_LEN);

    // ---- 5: clear mid-window together with a sample ----
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_reset();
    check("clr8_acc", 32'(acc_out8), 0);
    for (int i = 0; i < 7; i++) send(4'h5, 1'b0);
    check("pre_clr_acc", 32'(acc_out), 35);
    sum_in   = 4'h5;
    in_valid = 1'b1;
    clr      = 1'b1;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    model_reset();
    check("clr_acc", 32'(acc_out), 0);
    check("clr_cnt", 32'(sample_cnt), 0);
    for (int i = 0; i < WIN_LEN - 1; i++) send(4'h5, 1'b0);
    check("clr_not_done", 32'(acc_valid), 0);
    send(4'h5, 1'b0);
    in_valid = 1'b0;
    check("clr_win_acc", 32'(acc_out), 80);
    tick();

    // ---- 6: exhaustive a + b + c_in stream ----
    for (int i = 0; i < 512; i++) begin
      logic [4:0] r;
      logic [8:0] idx;
      idx = 9'(i);
      r   = 5'(idx[3:0]) + 5'(idx[7:4]) + 5'(idx[8]);
      send(r[3:0], r[4]);
    end
    in_valid = 1'b0;
    repeat (4) tick();
    check("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_adder_sum_accumulator
`default_nettype wire
